cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

Multi-cycle control unit for the simple CPU. It sequences every instruction through fetch, decode, execute, memory and write-back, handshakes with instruction and data memory, and times the multi-cycle MUL/DIV. It drives all datapath enables and selects. It sits inside `top` between the memories and the register file/ALU datapath, and decodes the 32-bit instruction format: offset[31:19], ra[18:14], rb[13:9], rd[8:4], opcode[3:0].

## Interface

- `DATAWIDTH`, 32: datapath and instruction width; must be 32.
- `MUL_LAT`, 3: EXEC cycles for MUL, ≥1.
- `DIV_LAT`, 8: EXEC cycles for DIV, ≥1.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `instr_i` in 32: instruction-register contents; valid from DECODE onward.
- `imem_ack_i` in 1: instruction memory has returned data.
- `dmem_ack_i` in 1: data memory access complete.
- `br_cond_i` in 1: datapath compare result for the current branch opcode; valid in EXEC.
- `imem_req_o` out 1: instruction fetch request.
- `ir_we_o` out 1: load instruction register.
- `dmem_req_o` out 1: data memory request.
- `dmem_we_o` out 1: data memory write (SW).
- `alu_op_o` out 4: opcode forwarded to ALU.
- `alu_start_o` out 1: one-cycle pulse on first EXEC cycle.
- `rf_we_o` out 1: register-file write enable.
- `rf_wsel_o` out 2: write-back source; 0=ALU, 1=MEM, 2=IMM.
- `pc_we_o` out 1: PC update.
- `pc_sel_o` out 2: next PC; 0=PC+4, 1=PC+sext(offset) branch, 2=jump target.
- `halt_o` out 1: illegal opcode seen; core stopped.
- `state_o` out 3: current state, debug.
- `cyc_cnt_o` out 32: cycle counter (see Configuration).
- `ret_cnt_o` out 32: retired-instruction counter (see Configuration).

## Operation

- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `imem_req_o`=1. When `imem_ack_i`=1, `ir_we_o`=1 in the same cycle and the next state is DECODE. Otherwise the FSM stays in FETCH.
- DECODE, one cycle:
  - Opcodes 0x0–0xD go to EXEC.
  - Opcodes 0xE and 0xF go to HALT.
- EXEC:
  - `alu_start_o` pulses in the first cycle.
  - MUL stays MUL_LAT cycles and DIV stays DIV_LAT cycles, timed by a down-counter. All other opcodes stay 1 cycle.
  - LW/SW go next to MEM; every other opcode goes to WB.
  - For BEQ/BGT/BGE, `br_cond_i` is registered in the last EXEC cycle.
- MEM: `dmem_req_o`=1. `dmem_we_o`=1 for SW only. Both are held until `dmem_ack_i`, then the FSM goes to WB.
- WB, one cycle: `pc_we_o`=1.
  - `pc_sel_o`=1 if a branch was taken, 2 for JMP, 0 otherwise.
  - `rf_we_o`=1 for ADD, SUB, MUL, DIV, AND, OR, XOR (wsel 0), LW (wsel 1) and LI (wsel 2).
  - `rf_we_o` is forced to 0 when rd==0 (r0 is read-only).
  - Next state is FETCH.
- HALT: absorbing. `halt_o`=1 and all requests and enables are 0. Only reset leaves HALT.
- `alu_op_o` = `instr_i[3:0]` in EXEC, MEM and WB; 0 otherwise.

## Timing

- Reset:
  - FSM state = FETCH.
  - Every output = 0, except `imem_req_o`, which goes to 1 once reset deasserts.
  - Counters = 0.
- Reset mid-operation aborts any memory request immediately. There is no completion handshake.
- Minimum cycles per instruction, with acks arriving in the same cycle as the request:
  - ALU/LI/branch/JMP: 4.
  - MUL: 3+MUL_LAT.
  - DIV: 3+DIV_LAT.
  - LW/SW: 5.
- Each cycle of ack delay adds one cycle.
- An ack outside its request state is ignored. Requests are level signals held until ack.
- The EXEC counter loads LAT-1 on entry and exits at 0.

## Configuration

- `CPU_CTRL_PERF_EN` defined:
  - `cyc_cnt_o` increments every cycle out of reset, including HALT.
  - `ret_cnt_o` increments on each WB cycle.
  - Both wrap modulo 2^32.
- `CPU_CTRL_PERF_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Structure

- `cpu_pkg` holds:
  - opcode enum `opcode_e` (ADD=0 … LI=0xD);
  - `state_e`;
  - `pc_sel_e` and `wsel_e` enums;
  - instruction field bit-position localparams.
- Sub-module `cpu_ctrl_decode`: combinational opcode → {is_alu, is_mem, is_store, is_branch, is_jmp, is_li, is_multi, illegal}.

## Test plan

- ADD r3←r1+r1, acks tied high → FETCH→DECODE→EXEC→WB in 4 cycles. In WB: `rf_we_o`=1, `rf_wsel_o`=0, `pc_sel_o`=0.
- LW with `dmem_ack_i` delayed 3 cycles → `dmem_req_o` high for 4 cycles with `dmem_we_o`=0. WB has `rf_wsel_o`=1. Total 8 cycles.
- BEQ offset 420 with `br_cond_i`=1, then with 0 → WB `pc_sel_o`=1 the first time and 0 the second. `rf_we_o`=0 both times.
- DIV with DIV_LAT=8 → EXEC lasts exactly 8 cycles and `alu_start_o` pulses once. ADD with rd=0 → `rf_we_o`=0.
- Opcode 0xF → HALT the cycle after DECODE, `halt_o`=1 and no further `imem_req_o`. Asserting `rst_i` mid-MEM → outputs clear asynchronously and the FSM returns to FETCH.
- With `CPU_CTRL_PERF_EN`, 3 ADDs → `ret_cnt_o`=3 and `cyc_cnt_o`=12. Without the macro → both read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle CPU control unit: opcodes, FSM states,
// datapath select encodings and instruction field positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'h0,
        OpSub = 4'h1,
        OpMul = 4'h2,
        OpDiv = 4'h3,
        OpAnd = 4'h4,
        OpOr  = 4'h5,
        OpXor = 4'h6,
        OpLw  = 4'h7,
        OpSw  = 4'h8,
        OpBeq = 4'h9,
        OpBgt = 4'hA,
        OpBge = 4'hB,
        OpJmp = 4'hC,
        OpLi  = 4'hD
    } opcode_e;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PcSeq    = 2'd0,
        PcBranch = 2'd1,
        PcJump   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WselAlu = 2'd0,
        WselMem = 2'd1,
        WselImm = 2'd2
    } wsel_e;

    // Instruction layout: offset[31:19] ra[18:14] rb[13:9] rd[8:4] opcode[3:0]
    localparam int unsigned OpcodeLsb = 0;
    localparam int unsigned OpcodeW   = 4;
    localparam int unsigned RdLsb     = 4;
    localparam int unsigned RbLsb     = 9;
    localparam int unsigned RaLsb     = 14;
    localparam int unsigned RegW      = 5;
    localparam int unsigned OffsetLsb = 19;
    localparam int unsigned OffsetW   = 13;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode classifier feeding the control FSM.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       is_alu_o,
    output logic       is_mem_o,
    output logic       is_store_o,
    output logic       is_branch_o,
    output logic       is_jmp_o,
    output logic       is_li_o,
    output logic       is_multi_o,
    output logic       illegal_o
);

    // Map each opcode onto the control groups; 0xE/0xF are illegal
    always_comb begin
        is_alu_o    = 1'b0;
        is_mem_o    = 1'b0;
        is_store_o  = 1'b0;
        is_branch_o = 1'b0;
        is_jmp_o    = 1'b0;
        is_li_o     = 1'b0;
        is_multi_o  = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OpAdd, OpSub, OpAnd, OpOr, OpXor: is_alu_o = 1'b1;
            OpMul, OpDiv: begin
                is_alu_o   = 1'b1;
                is_multi_o = 1'b1;
            end
            OpLw: is_mem_o = 1'b1;
            OpSw: begin
                is_mem_o   = 1'b1;
                is_store_o = 1'b1;
            end
            OpBeq, OpBgt, OpBge: is_branch_o = 1'b1;
            OpJmp: is_jmp_o = 1'b1;
            OpLi:  is_li_o  = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with HALT
// on illegal opcodes. Optional performance counters are built only when
// CPU_CTRL_PERF_EN is defined; otherwise cyc_cnt_o/ret_cnt_o read zero.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned MUL_LAT   = 3,
    parameter int unsigned DIV_LAT   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATAWIDTH-1:0] instr_i,
    input  logic                 imem_ack_i,
    input  logic                 dmem_ack_i,
    input  logic                 br_cond_i,
    output logic                 imem_req_o,
    output logic                 ir_we_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [3:0]           alu_op_o,
    output logic                 alu_start_o,
    output logic                 rf_we_o,
    output logic [1:0]           rf_wsel_o,
    output logic                 pc_we_o,
    output logic [1:0]           pc_sel_o,
    output logic                 halt_o,
    output logic [2:0]           state_o,
    output logic [DATAWIDTH-1:0] cyc_cnt_o,
    output logic [DATAWIDTH-1:0] ret_cnt_o
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    // Counter only needs to hold LAT-1
    localparam int unsigned CntW   = (MaxLat > 2) ? $clog2(MaxLat) : 1;
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 1);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_LAT - 1);

    logic [3:0]      opcode;
    logic [RegW-1:0] rd;
    logic            rd_nz;
    logic            unused_instr;

    logic is_alu, is_mem, is_store, is_branch, is_jmp, is_li, is_multi, illegal;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            first_q;
    logic            br_taken_q;

    assign opcode       = instr_i[OpcodeLsb +: OpcodeW];
    assign rd           = instr_i[RdLsb +: RegW];
    assign rd_nz        = |rd;
    // Offset and source registers are consumed by the datapath, not here
    assign unused_instr = ^instr_i[DATAWIDTH-1:RbLsb];

    cpu_ctrl_decode u_decode (
        .opcode_i    (opcode),
        .is_alu_o    (is_alu),
        .is_mem_o    (is_mem),
        .is_store_o  (is_store),
        .is_branch_o (is_branch),
        .is_jmp_o    (is_jmp),
        .is_li_o     (is_li),
        .is_multi_o  (is_multi),
        .illegal_o   (illegal)
    );

    // Control FSM: state, EXEC latency down-counter and branch outcome
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StFetch;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ack_i) state_q <= StDecode;
                end
                StDecode: begin
                    br_taken_q <= 1'b0;
                    if (illegal) begin
                        state_q <= StHalt;
                    end else begin
                        state_q <= StExec;
                        first_q <= 1'b1;
                        if (!is_multi)             cnt_q <= '0;
                        else if (opcode == OpMul)  cnt_q <= MulLoad;
                        else                       cnt_q <= DivLoad;
                    end
                end
                StExec: begin
                    first_q <= 1'b0;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        br_taken_q <= is_branch & br_cond_i;
                        state_q    <= is_mem ? StMem : StWb;
                    end
                end
                StMem: begin
                    if (dmem_ack_i) state_q <= StWb;
                end
                StWb:    state_q <= StFetch;
                StHalt:  state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Datapath enables/selects decoded from the current state
    always_comb begin
        imem_req_o  = 1'b0;
        ir_we_o     = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        alu_op_o    = 4'h0;
        alu_start_o = 1'b0;
        rf_we_o     = 1'b0;
        rf_wsel_o   = WselAlu;
        pc_we_o     = 1'b0;
        pc_sel_o    = PcSeq;
        halt_o      = 1'b0;
        unique case (state_q)
            StFetch: begin
                // Held low while reset is asserted so a reset aborts the request
                imem_req_o = ~rst_i;
                ir_we_o    = ~rst_i & imem_ack_i;
            end
            StExec: begin
                alu_op_o    = opcode;
                alu_start_o = first_q;
            end
            StMem: begin
                alu_op_o   = opcode;
                dmem_req_o = 1'b1;
                dmem_we_o  = is_store;
            end
            StWb: begin
                alu_op_o = opcode;
                pc_we_o  = 1'b1;
                if (br_taken_q)  pc_sel_o = PcBranch;
                else if (is_jmp) pc_sel_o = PcJump;
                rf_we_o = (is_alu | is_li | (is_mem & ~is_store)) & rd_nz;
                if (is_li)                   rf_wsel_o = WselImm;
                else if (is_mem & ~is_store) rf_wsel_o = WselMem;
            end
            StHalt:  halt_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

`ifdef CPU_CTRL_PERF_EN
    logic [DATAWIDTH-1:0] cyc_cnt_q;
    logic [DATAWIDTH-1:0] ret_cnt_q;

    // Free-running cycle count and retired-instruction count, both wrapping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
            if (state_q == StWb) ret_cnt_q <= ret_cnt_q + 1'b1;
        end
    end

    assign cyc_cnt_o = cyc_cnt_q;
    assign ret_cnt_o = ret_cnt_q;
`else
    assign cyc_cnt_o = '0;
    assign ret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: each issued instruction pushes its expected
// write-back profile; a monitor pops and compares on every pc_we_o cycle.
module tb_cpu_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ack, dmem_ack, br_cond;
    logic        imem_req, ir_we, dmem_req, dmem_we, alu_start, rf_we, pc_we, halt;
    logic [3:0]  alu_op;
    logic [1:0]  rf_wsel, pc_sel;
    logic [2:0]  state;
    logic [31:0] cyc_cnt, ret_cnt;

    int checks = 0;
    int fails  = 0;

    cpu_ctrl #(
        .DATAWIDTH (32),
        .MUL_LAT   (3),
        .DIV_LAT   (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .instr_i     (instr),
        .imem_ack_i  (imem_ack),
        .dmem_ack_i  (dmem_ack),
        .br_cond_i   (br_cond),
        .imem_req_o  (imem_req),
        .ir_we_o     (ir_we),
        .dmem_req_o  (dmem_req),
        .dmem_we_o   (dmem_we),
        .alu_op_o    (alu_op),
        .alu_start_o (alu_start),
        .rf_we_o     (rf_we),
        .rf_wsel_o   (rf_wsel),
        .pc_we_o     (pc_we),
        .pc_sel_o    (pc_sel),
        .halt_o      (halt),
        .state_o     (state),
        .cyc_cnt_o   (cyc_cnt),
        .ret_cnt_o   (ret_cnt)
    );

    always #5 clk = ~clk;

    // Memory responders: ack in the (dly+1)th cycle of a held request
    int imem_dly = 0, dmem_dly = 0;
    int icnt, dcnt;
    assign imem_ack = imem_req && (icnt == imem_dly);
    assign dmem_ack = dmem_req && (dcnt == dmem_dly);
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        end
    end

    typedef struct {
        string name;
        int    cyc;
        int    exec;
        int    dreq;
        int    dwe;
        int    rfwe;
        int    wsel;
        int    pcsel;
        int    op;
    } exp_t;

    exp_t exp_q[$];

    function automatic void chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    function automatic exp_t mk(input string n, input int cyc, input int exec, input int dreq,
                                input int dwe, input int rfwe, input int wsel, input int pcsel,
                                input int op);
        exp_t e;
        e.name = n; e.cyc = cyc; e.exec = exec; e.dreq = dreq; e.dwe = dwe;
        e.rfwe = rfwe; e.wsel = wsel; e.pcsel = pcsel; e.op = op;
        return e;
    endfunction

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input logic [12:0] off);
        return {off, ra, rb, rd, op};
    endfunction

    // Monitor: accumulate per-instruction activity, compare on write-back
    int m_cyc, m_exec, m_start, m_dreq, m_dwe, m_irwe;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            m_cyc = 0; m_exec = 0; m_start = 0; m_dreq = 0; m_dwe = 0; m_irwe = 0;
        end else begin
            m_cyc++;
            if (state == 3'd2) m_exec++;
            if (alu_start) m_start++;
            if (dmem_req) m_dreq++;
            if (dmem_we) m_dwe++;
            if (ir_we) m_irwe++;
            if (pc_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL wb_unexpected: got write-back expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "/cycles"}, m_cyc, e.cyc);
                    chk({e.name, "/exec_cycles"}, m_exec, e.exec);
                    chk({e.name, "/alu_start"}, m_start, 1);
                    chk({e.name, "/ir_we"}, m_irwe, 1);
                    chk({e.name, "/dmem_req"}, m_dreq, e.dreq);
                    chk({e.name, "/dmem_we"}, m_dwe, e.dwe);
                    chk({e.name, "/rf_we"}, int'(rf_we), e.rfwe);
                    if (e.rfwe != 0) chk({e.name, "/rf_wsel"}, int'(rf_wsel), e.wsel);
                    chk({e.name, "/pc_sel"}, int'(pc_sel), e.pcsel);
                    chk({e.name, "/alu_op"}, int'(alu_op), e.op);
                end
                m_cyc = 0; m_exec = 0; m_start = 0; m_dreq = 0; m_dwe = 0; m_irwe = 0;
            end
        end
    end

    // Drive one instruction and wait (bounded) for its write-back
    task automatic issue(input logic [31:0] ins, input int idly, input int ddly,
                         input logic br, input exp_t e);
        logic seen;
        instr    = ins;
        imem_dly = idly;
        dmem_dly = ddly;
        br_cond  = br;
        exp_q.push_back(e);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = pc_we;
        end
        #1;
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL %s/timeout: got no write-back expected one within 200 cycles", e.name);
        end
    endtask

    initial begin
        int n;
        int req_cnt, halt_cnt;
        logic seen;

        rst     = 1'b1;
        instr   = enc(OpAdd, 5'd3, 5'd1, 5'd1, 13'd0);
        br_cond = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/imem_req", int'(imem_req), 0);
        chk("reset/state", int'(state), 0);
        chk("reset/pc_we", int'(pc_we), 0);
        chk("reset/halt", int'(halt), 0);
        chk("reset/alu_op", int'(alu_op), 0);
        chk("reset/cyc_cnt", int'(cyc_cnt), 0);
        chk("reset/ret_cnt", int'(ret_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("reset_release/imem_req", int'(imem_req), 1);

        // Three back-to-back ADDs straight out of reset for the perf counters
        for (int i = 0; i < 3; i++)
            issue(enc(OpAdd, 5'd3, 5'd1, 5'd1, 13'd0), 0, 0, 1'b0,
                  mk("add", 4, 1, 0, 0, 1, 0, 0, 0));
        @(posedge clk);
        #1;
`ifdef CPU_CTRL_PERF_EN
        chk("perf/cyc_cnt", int'(cyc_cnt), 12);
        chk("perf/ret_cnt", int'(ret_cnt), 3);
`else
        chk("perf/cyc_cnt", int'(cyc_cnt), 0);
        chk("perf/ret_cnt", int'(ret_cnt), 0);
`endif

        issue(enc(OpAdd, 5'd3, 5'd1, 5'd1, 13'd0), 2, 0, 1'b0,
              mk("add_imem_wait2", 6, 1, 0, 0, 1, 0, 0, 0));
        issue(enc(OpLw, 5'd5, 5'd2, 5'd0, 13'd16), 0, 3, 1'b0,
              mk("lw_dmem_wait3", 8, 1, 4, 0, 1, 1, 0, 7));
        issue(enc(OpSw, 5'd0, 5'd2, 5'd5, 13'd16), 0, 1, 1'b0,
              mk("sw_dmem_wait1", 6, 1, 2, 2, 0, 0, 0, 8));
        issue(enc(OpBeq, 5'd0, 5'd1, 5'd2, 13'd420), 0, 0, 1'b1,
              mk("beq_taken", 4, 1, 0, 0, 0, 0, 1, 9));
        issue(enc(OpBeq, 5'd0, 5'd1, 5'd2, 13'd420), 0, 0, 1'b0,
              mk("beq_not_taken", 4, 1, 0, 0, 0, 0, 0, 9));
        issue(enc(OpBge, 5'd0, 5'd1, 5'd2, 13'd8), 0, 0, 1'b1,
              mk("bge_taken", 4, 1, 0, 0, 0, 0, 1, 11));
        issue(enc(OpDiv, 5'd4, 5'd1, 5'd2, 13'd0), 0, 0, 1'b0,
              mk("div", 11, 8, 0, 0, 1, 0, 0, 3));
        issue(enc(OpMul, 5'd6, 5'd1, 5'd2, 13'd0), 0, 0, 1'b0,
              mk("mul", 6, 3, 0, 0, 1, 0, 0, 2));
        issue(enc(OpAdd, 5'd0, 5'd1, 5'd1, 13'd0), 0, 0, 1'b0,
              mk("add_rd0", 4, 1, 0, 0, 0, 0, 0, 0));
        issue(enc(OpLi, 5'd7, 5'd0, 5'd0, 13'd99), 0, 0, 1'b0,
              mk("li", 4, 1, 0, 0, 1, 2, 0, 13));
        issue(enc(OpJmp, 5'd0, 5'd1, 5'd0, 13'd0), 0, 0, 1'b0,
              mk("jmp", 4, 1, 0, 0, 0, 0, 2, 12));
        issue(enc(OpXor, 5'd2, 5'd1, 5'd3, 13'd0), 0, 0, 1'b1,
              mk("xor_brcond_ignored", 4, 1, 0, 0, 1, 0, 0, 6));
        chk("scoreboard_drained", exp_q.size(), 0);

        // Reset asserted while a load is stalled in MEM
        instr    = enc(OpLw, 5'd5, 5'd2, 5'd0, 13'd0);
        dmem_dly = 1000;
        seen     = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = dmem_req;
        end
        chk("mid_mem/reached_mem", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_mem_reset/dmem_req", int'(dmem_req), 0);
        chk("mid_mem_reset/state", int'(state), 0);
        chk("mid_mem_reset/alu_op", int'(alu_op), 0);
        chk("mid_mem_reset/imem_req", int'(imem_req), 0);

        // Illegal opcode 0xF halts after DECODE
        instr    = 32'h0000_000F;
        dmem_dly = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            seen = halt;
        end
        chk("halt/latency_cycles", n, 3);
        chk("halt/state", int'(state), 5);
        req_cnt  = 0;
        halt_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (imem_req) req_cnt++;
            if (halt) halt_cnt++;
        end
        chk("halt/imem_req_cycles", req_cnt, 0);
        chk("halt/halt_cycles", halt_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
